// File: rtl/mdu_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit:
// operand width, funct3 opcodes and FSM state encodings.
package mdu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

endpackage

// File: rtl/mul_div_unit_if.sv
// Controller <-> multiply/divide unit bundle: the request side and the
// result/stall side that feeds the phase-clock generator.
interface mul_div_unit_if #(
  parameter int XLEN = mdu_pkg::XLEN
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] result;
  logic            result_valid;
  logic            alu_complete;

  modport master (
    output start, funct3, op_a, op_b,
    input  result, result_valid, alu_complete
  );

  modport slave (
    input  start, funct3, op_a, op_b,
    output result, result_valid, alu_complete
  );
endinterface

// File: rtl/mdu_sign_fix.sv
// Final sign correction, special-case override and result selection for
// the multiply/divide unit; purely combinational.
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int XLEN = mdu_pkg::XLEN
) (
  input  logic [2*XLEN-1:0] prod,
  input  logic [XLEN-1:0]   quo,
  input  logic [XLEN-1:0]   rem,
  input  logic              sign_a,
  input  logic              sign_b,
  input  logic              div_zero,
  input  logic              div_ovf,
  input  logic [2:0]        funct3,
  output logic [XLEN-1:0]   result
);

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;

  // MULHSU never sets sign_b, so one xor covers every multiply flavour
  always_comb begin
    prod_s = (sign_a ^ sign_b) ? -prod : prod;

    quo_s = (sign_a ^ sign_b) ? -quo : quo;
    if (div_zero)
      quo_s = '1;
    else if (div_ovf)
      quo_s = {1'b1, {(XLEN-1){1'b0}}};

    rem_s = sign_a ? -rem : rem;
    if (div_ovf)
      rem_s = '0;

    case (funct3)
      F3_MUL:                        result = prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  result = prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               result = quo_s;
      default:                       result = rem_s;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit; holds alu_complete low while an
// operation is in flight so the phase clocks stall.
//
// state  | meaning
// S_IDLE | waiting for a start rising edge, alu_complete high
// S_MUL  | shift-add, one multiplier bit per cycle
// S_DIV  | restoring divide, one quotient bit per cycle
// S_FIX  | sign correction, result write, result_valid pulse
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int XLEN = mdu_pkg::XLEN
) (
  input logic           clk_100M,
  input logic           rst_n,
  mul_div_unit_if.slave bus
);

  localparam int CW = $clog2(XLEN);

  logic [1:0]        state_q, state_d;
  logic              start_d_q, start_d_d;
  logic [2:0]        f3_q, f3_d;
  logic              sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic              dz_q, dz_d, ovf_q, ovf_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  logic              is_div, a_signed, b_signed, sa, sb, b_zero, ovf_case, last;
  logic [XLEN-1:0]   mag_a, mag_b, fixed;
  logic [XLEN:0]     mul_sum, shifted, diff;
  logic              ge;

  always_comb begin
    is_div   = bus.funct3[2];
    a_signed = (bus.funct3 == F3_MUL) || (bus.funct3 == F3_MULH) || (bus.funct3 == F3_MULHSU)
            || (bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM);
    b_signed = (bus.funct3 == F3_MUL) || (bus.funct3 == F3_MULH)
            || (bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM);
    sa       = a_signed & bus.op_a[XLEN-1];
    sb       = b_signed & bus.op_b[XLEN-1];
    mag_a    = sa ? -bus.op_a : bus.op_a;
    mag_b    = sb ? -bus.op_b : bus.op_b;
    b_zero   = (bus.op_b == '0);
    ovf_case = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM))
            && (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);

    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    shifted  = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
    ge       = (shifted >= {1'b0, mcand_q});
    diff     = shifted - {1'b0, mcand_q};
    last     = (cnt_q == CW'(XLEN-1));
  end

  always_comb begin
    state_d   = state_q;
    start_d_d = bus.start;
    f3_d      = f3_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    mcand_d   = mcand_q;
    result_d  = result_q;
    valid_d   = 1'b0;
    done_d    = done_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !start_d_q) begin
          f3_d     = bus.funct3;
          sign_a_d = sa;
          sign_b_d = sb;
          mcand_d  = mag_b;
          acc_d    = {{XLEN{1'b0}}, mag_a};
          cnt_d    = '0;
          done_d   = 1'b0;
          dz_d     = is_div & b_zero;
          ovf_d    = ovf_case;
          // divide-by-zero remainder is the dividend; sign fix restores op_a
          rem_d    = (is_div && b_zero) ? {1'b0, mag_a} : '0;
          if ((is_div && b_zero) || ovf_case) state_d = S_FIX;
          else if (is_div)                    state_d = S_DIV;
          else                                state_d = S_MUL;
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (last) state_d = S_FIX;
      end
      S_DIV: begin
        rem_d = ge ? diff : shifted;
        acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ge};
        cnt_d = cnt_q + CW'(1);
        if (last) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = fixed;
        valid_d  = 1'b1;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      start_d_q <= 1'b0;
      f3_q      <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      mcand_q   <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      start_d_q <= start_d_d;
      f3_q      <= f3_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      mcand_q   <= mcand_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  mdu_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .prod     (acc_q),
    .quo      (acc_q[XLEN-1:0]),
    .rem      (rem_q[XLEN-1:0]),
    .sign_a   (sign_a_q),
    .sign_b   (sign_b_q),
    .div_zero (dz_q),
    .div_ovf  (ovf_q),
    .funct3   (f3_q),
    .result   (fixed)
  );

  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign bus.alu_complete = done_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed vector bench for mul_div_unit: result values, stall length,
// result_valid pulse, start-edge handling and mid-operation reset.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic clk_100M = 1'b0;
  logic rst_n    = 1'b0;
  always #5 clk_100M = ~clk_100M;

  mul_div_unit_if #(.XLEN(32)) bus ();

  mul_div_unit #(.XLEN(32)) dut (
    .clk_100M (clk_100M),
    .rst_n    (rst_n),
    .bus      (bus.slave)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One complete operation; optionally scrambles the inputs while busy.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, output logic [31:0] res, output int low,
                        output int pulses, output bit vrise);
    low = 0; pulses = 0; vrise = 1'b0;
    @(posedge clk_100M); #1;
    bus.funct3 = f3; bus.op_a = a; bus.op_b = b; bus.start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_100M); #1;
      if (bus.result_valid) pulses++;
      if (!bus.alu_complete) begin
        low++;
        if (scramble) begin
          bus.op_a = ~a; bus.op_b = b + 32'd1; bus.funct3 = f3 ^ 3'b001;
        end
      end else if (low > 0) begin
        vrise = bus.result_valid;
        break;
      end
    end
    res = bus.result;
    bus.start = 1'b0;
    @(posedge clk_100M); #1;
    if (bus.result_valid) pulses++;
  endtask

  initial begin
    logic [31:0] res;
    int          low, pulses;
    bit          vrise;

    vecs[0]  = '{F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33};
    vecs[2]  = '{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[3]  = '{F3_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33};
    vecs[4]  = '{F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[5]  = '{F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[6]  = '{F3_DIVU,   32'd100,      32'd7,        32'd14,       33};
    vecs[7]  = '{F3_REMU,   32'd100,      32'd7,        32'd2,        33};
    vecs[8]  = '{F3_DIVU,   32'd100,      32'd0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{F3_REMU,   32'd100,      32'd0,        32'h00000064, 1};
    vecs[10] = '{F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[11] = '{F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    vecs[12] = '{F3_MUL,    32'h12345678, 32'h00000010, 32'h23456780, 33};
    vecs[13] = '{F3_MULHU,  32'h12345678, 32'h00000010, 32'h00000001, 33};
    vecs[14] = '{F3_DIV,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1};
    vecs[15] = '{F3_REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1};
    vecs[16] = '{F3_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    vecs[17] = '{F3_REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, 33};

    bus.start = 1'b0; bus.funct3 = '0; bus.op_a = '0; bus.op_b = '0;
    repeat (3) @(posedge clk_100M);
    #1;
    check("reset_alu_complete", {31'd0, bus.alu_complete}, 32'd1);
    check("reset_result",       bus.result,                32'd0);
    check("reset_result_valid", {31'd0, bus.result_valid}, 32'd0);
    @(negedge clk_100M);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, 1'b0, res, low, pulses, vrise);
      check($sformatf("v%0d_result", i),      res,            vecs[i].exp);
      check($sformatf("v%0d_stall_cycles", i), 32'(low),      32'(vecs[i].lat));
      check($sformatf("v%0d_valid_pulses", i), 32'(pulses),   32'd1);
      check($sformatf("v%0d_valid_at_rise", i), {31'd0, vrise}, 32'd1);
    end

    // start held high for 50 cycles: a single operation
    @(posedge clk_100M); #1;
    bus.funct3 = F3_DIVU; bus.op_a = 32'd100; bus.op_b = 32'd7; bus.start = 1'b1;
    low = 0; pulses = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk_100M); #1;
      if (!bus.alu_complete) low++;
      if (bus.result_valid) pulses++;
    end
    bus.start = 1'b0;
    check("held_start_stall_cycles", 32'(low),    32'd33);
    check("held_start_pulses",       32'(pulses), 32'd1);
    check("held_start_result",       bus.result,  32'd14);

    // second rising edge around cycle 10 of a MUL is dropped
    @(posedge clk_100M); #1;
    bus.funct3 = F3_MUL; bus.op_a = 32'd7; bus.op_b = 32'hFFFFFFFD; bus.start = 1'b1;
    low = 0; pulses = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk_100M); #1;
      if (!bus.alu_complete) low++;
      if (bus.result_valid) pulses++;
      if (i == 0) bus.start = 1'b0;
      if (i == 9) begin
        bus.start = 1'b1; bus.op_a = 32'd5; bus.op_b = 32'd5;
      end
    end
    bus.start = 1'b0;
    check("retrigger_stall_cycles", 32'(low),    32'd33);
    check("retrigger_pulses",       32'(pulses), 32'd1);
    check("retrigger_result",       bus.result,  32'hFFFFFFEB);

    // operands and funct3 changed after the start edge
    run_op(F3_DIVU, 32'd100, 32'd7, 1'b1, res, low, pulses, vrise);
    check("scramble_result",       res,      32'd14);
    check("scramble_stall_cycles", 32'(low), 32'd33);

    // asynchronous reset in the middle of a divide
    @(posedge clk_100M); #1;
    bus.funct3 = F3_DIVU; bus.op_a = 32'hFFFFFFFF; bus.op_b = 32'd3; bus.start = 1'b1;
    repeat (15) @(posedge clk_100M);
    #3;
    check("midreset_busy_before", {31'd0, bus.alu_complete}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("midreset_alu_complete", {31'd0, bus.alu_complete}, 32'd1);
    check("midreset_result",       bus.result,                32'd0);
    check("midreset_result_valid", {31'd0, bus.result_valid}, 32'd0);
    bus.start = 1'b0;
    @(negedge clk_100M);
    rst_n = 1'b1;
    run_op(F3_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, res, low, pulses, vrise);
    check("post_reset_result",       res,         32'hFFFFFFFD);
    check("post_reset_stall_cycles", 32'(low),    32'd33);
    check("post_reset_pulses",       32'(pulses), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
